axi4_stream_rr_pkt_arbiter: RTL
===============================

# axi4_stream_rr_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI4-Stream datapath (typically the input of the multiple-ratio downsizer) between several requesting streams. Grant is taken on a packet boundary and held until the granted packet's tlast beat is accepted, so packets never interleave downstream. A single registered output stage decouples the selected input from the downstream datapath at full throughput.

## Interface
- TDATA_WIDTH, 64, tdata width of every input and of the output; multiple of 8.
- INPUTS_AMOUNT, 4, number of requesting streams; ≥ 2.
- GRANT_WIDTH, $clog2( INPUTS_AMOUNT ), width of the grant index (derived, not overridden).

- clk_i  input  1  single clock.
- rst_i  input  1  reset; asynchronous, active-high.
- pkt_i  axi4_stream_if.slave  array [INPUTS_AMOUNT]  requesting streams; tdata TDATA_WIDTH, tkeep/tstrb TDATA_WIDTH/8, tuser/tdest/tid/tlast 1 bit.
- pkt_o  axi4_stream_if.master  same widths  arbitrated stream toward the shared datapath.
- grant_o  output  GRANT_WIDTH  index of the input currently owning the output; valid while busy_o.
- busy_o  output  1  high while a packet is granted (state PKT).

## Operation
- States: IDLE, PKT.
- IDLE: if any pkt_i[k].tvalid, pick the first k with tvalid in order last_grant+1, last_grant+2, … wrapping modulo INPUTS_AMOUNT; register grant <= k, go PKT. No input accepted in IDLE. No requests: stay IDLE.
- PKT: pkt_i[grant].tready = stage_ready; all other tready = 0. Accepted beat (tdata, tkeep, tstrb, tuser, tdest, tid, tlast) copied unchanged into the output register.
- Output register: stage_ready = !out_valid || pkt_o.tready. Load on input handshake; out_valid cleared when pkt_o handshakes and no new beat loads in the same cycle.
- Granted input handshake with tlast = 1: last_grant <= grant, go IDLE in the same edge.
- Granted input dropping tvalid mid-packet: grant held, no rearbitration, output drains normally.
- Requests from non-granted inputs never affect the current packet.
- Round-robin fairness: with all inputs constantly requesting, grant order 0,1,…,N-1,0,…; each input waits at most N-1 packets.
- Reset values: state IDLE, last_grant = INPUTS_AMOUNT-1 (input 0 has first priority), grant 0, out_valid 0, all pkt_i.tready 0, pkt_o.tvalid 0, pkt_o.tlast 0, busy_o 0, grant_o 0, output data registers 0.
- Reset asserted mid-packet: all of the above immediately (asynchronous); partial packet discarded, downstream sees tvalid fall; no recovery action.

## Timing
- Arbitration: request visible in cycle n → grant registered at edge n, tready to winner in cycle n+1.
- Datapath latency: input handshake at edge m → beat on pkt_o from cycle m+1.
- Throughput in PKT: one beat per cycle while pkt_o.tready = 1 (pass-through of tready via stage_ready, no bubble).
- Packet gap: one IDLE cycle between tlast acceptance and the next grant; the last beat of the previous packet may still be in the output register during that cycle and the first beat of the next.
- busy_o/grant_o are registered state outputs; change on the edge that enters/leaves PKT.
- Backpressure: pkt_o.tready = 0 with out_valid = 1 → granted tready = 0 combinationally in the same cycle; output register holds all fields stable.

## Test plan
- Reset then input 2 alone sends 3-beat packet (tdata 0xA0..0xA2, tlast on beat 3) → busy_o 1 next edge, grant_o 2, pkt_o carries 0xA0..0xA2 each one cycle after acceptance, tlast only on 0xA2, busy_o 0 after tlast handshake.
- All 4 inputs continuously send 2-beat packets → grant_o sequence 0,1,2,3,0; no interleaving; one idle cycle between packets.
- Single-beat packets (tlast on first beat) on inputs 1 and 3 simultaneously → input 1 served first, then 3; each packet exactly one pkt_o beat.
- Random pkt_o.tready (50 %) with granted input toggling tvalid mid-packet → output beats in order, no loss/duplication, fields stable while tvalid && !tready, non-granted tready always 0.
- Assert rst_i during beat 2 of a 4-beat packet → pkt_o.tvalid, all tready, busy_o 0 immediately; after release, input 0 wins if requesting with input 3.

Source files
------------

// File: rtl/axi4_stream_rr_pkt_arbiter_if.sv
// AXI4-Stream bundle shared by the arbiter's requesting inputs and its output.
//   tdata  TDATA_WIDTH bits, tkeep/tstrb TDATA_WIDTH/8 bits,
//   tuser/tdest/tid/tlast 1 bit, tvalid/tready handshake.
//   master : drives payload and tvalid, receives tready.
//   slave  : receives payload and tvalid, drives tready.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 64
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tuser;
  logic                     tdest;
  logic                     tid;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata, tkeep, tstrb, tuser, tdest, tid, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tstrb, tuser, tdest, tid, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_rr_pkt_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI4-Stream output between
// INPUTS_AMOUNT requesting streams. A grant is taken only between packets and
// held until the granted packet's tlast beat is accepted, so packets never
// interleave. One registered output stage sits between the selected input and
// the output, with tready passed through so a full-rate stream sees no bubble.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   pkt_i    : requesting streams (slave modport array)
//   pkt_o    : arbitrated stream (master modport)
//   grant_o  : index of the input owning the output, meaningful while busy_o
//   busy_o   : high while a packet is granted
module axi4_stream_rr_pkt_arbiter #(
  parameter  int TDATA_WIDTH   = 64,
  parameter  int INPUTS_AMOUNT = 4,
  localparam int GRANT_WIDTH   = $clog2(INPUTS_AMOUNT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  axi4_stream_if.slave           pkt_i [INPUTS_AMOUNT],
  axi4_stream_if.master          pkt_o,
  output logic [GRANT_WIDTH-1:0] grant_o,
  output logic                   busy_o
);

  localparam int KEEP_W = TDATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [GRANT_WIDTH-1:0] grant;
  logic [GRANT_WIDTH-1:0] grant_nxt;
  logic [GRANT_WIDTH-1:0] last_grant;
  logic [GRANT_WIDTH-1:0] last_grant_nxt;

  logic [INPUTS_AMOUNT-1:0] in_valid;
  logic [INPUTS_AMOUNT-1:0] in_last;
  logic [INPUTS_AMOUNT-1:0] in_user;
  logic [INPUTS_AMOUNT-1:0] in_dest;
  logic [INPUTS_AMOUNT-1:0] in_id;
  logic [TDATA_WIDTH-1:0]   in_data [INPUTS_AMOUNT];
  logic [KEEP_W-1:0]        in_keep [INPUTS_AMOUNT];
  logic [KEEP_W-1:0]        in_strb [INPUTS_AMOUNT];

  logic                   stage_ready;
  logic                   in_hs;
  logic                   req_found;
  logic [GRANT_WIDTH-1:0] req_idx;
  logic [GRANT_WIDTH-1:0] cand;

  logic                   vld_p1;
  logic [TDATA_WIDTH-1:0] tdata_p1;
  logic [KEEP_W-1:0]      tkeep_p1;
  logic [KEEP_W-1:0]      tstrb_p1;
  logic                   tuser_p1;
  logic                   tdest_p1;
  logic                   tid_p1;
  logic                   tlast_p1;

  // Stage p0: flatten the interface array so the granted input can be
  // selected with a variable index; only the owner ever sees tready.
  for (genvar k = 0; k < INPUTS_AMOUNT; k++) begin : g_in
    assign in_valid[k] = pkt_i[k].tvalid;
    assign in_last[k]  = pkt_i[k].tlast;
    assign in_user[k]  = pkt_i[k].tuser;
    assign in_dest[k]  = pkt_i[k].tdest;
    assign in_id[k]    = pkt_i[k].tid;
    assign in_data[k]  = pkt_i[k].tdata;
    assign in_keep[k]  = pkt_i[k].tkeep;
    assign in_strb[k]  = pkt_i[k].tstrb;
    assign pkt_i[k].tready = (state == PKT) && (grant == GRANT_WIDTH'(k)) && stage_ready;
  end

  assign stage_ready = !vld_p1 || pkt_o.tready;
  assign in_hs       = (state == PKT) && in_valid[grant] && stage_ready;

  // Search starts one past the previous winner, so the last served input
  // has the lowest priority next time.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= INPUTS_AMOUNT; i++) begin
      cand = GRANT_WIDTH'((int'(last_grant) + i) % INPUTS_AMOUNT);
      if (!req_found && in_valid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (req_found) begin
          grant_nxt = req_idx;
          state_nxt = PKT;
        end
      end
      PKT: begin
        if (in_hs && in_last[grant]) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GRANT_WIDTH'(INPUTS_AMOUNT - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Stage p1: output register. A new beat may load in the same cycle the
  // held one leaves, which keeps a continuous stream at one beat per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tstrb_p1 <= '0;
      tuser_p1 <= 1'b0;
      tdest_p1 <= 1'b0;
      tid_p1   <= 1'b0;
      tlast_p1 <= 1'b0;
    end else if (in_hs) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= in_data[grant];
      tkeep_p1 <= in_keep[grant];
      tstrb_p1 <= in_strb[grant];
      tuser_p1 <= in_user[grant];
      tdest_p1 <= in_dest[grant];
      tid_p1   <= in_id[grant];
      tlast_p1 <= in_last[grant];
    end else if (pkt_o.tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign pkt_o.tvalid = vld_p1;
  assign pkt_o.tdata  = tdata_p1;
  assign pkt_o.tkeep  = tkeep_p1;
  assign pkt_o.tstrb  = tstrb_p1;
  assign pkt_o.tuser  = tuser_p1;
  assign pkt_o.tdest  = tdest_p1;
  assign pkt_o.tid    = tid_p1;
  assign pkt_o.tlast  = tlast_p1;

  assign busy_o  = (state == PKT);
  assign grant_o = grant;

endmodule
